// File: rtl/comb_enum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comb_enum_pkg
//  Description : Shared constants, FSM state type and first/last word
//                helpers for the fixed-popcount word enumerator.
//  Revision    : 1.0  initial release
// ============================================================================
package comb_enum_pkg;

    localparam int N  = 8;  // word width
    localparam int CW = 4;  // count width, clog2(N+1)
    localparam int IW = 7;  // index width, covers C(8,4)-1 = 69

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest N-bit word with k ones: k ones packed at the bottom.
    function automatic logic [N-1:0] first_word(input logic [CW-1:0] k);
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) begin
            w[i] = (i < int'(k));
        end
        return w;
    endfunction

    // Largest N-bit word with k ones: k ones packed at the top.
    function automatic logic [N-1:0] last_word(input logic [CW-1:0] k);
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) begin
            w[i] = (i >= (N - int'(k)));
        end
        return w;
    endfunction

endpackage : comb_enum_pkg
`default_nettype wire

// File: rtl/comb_enum8_next8.sv
`default_nettype none
// ============================================================================
//  Module      : comb_next8
//  Description : Combinational colex (Gosper) successor of an 8-bit word:
//                the next larger word with the same population count.
//  Revision    : 1.0  initial release
// ============================================================================
module comb_next8
    import comb_enum_pkg::*;
(
    input  logic [N-1:0] x,
    output logic [N-1:0] nxt
);

    logic [N-1:0] w_c;      // lowest set bit of x
    logic [N-1:0] w_r;      // x with its lowest run of ones carried out
    logic [N-1:0] w_rx;     // bits changed by the carry
    logic [2:0]   w_ctz;    // trailing-zero count of w_c

    assign w_c  = x & (~x + 8'd1);
    assign w_r  = x + w_c;
    assign w_rx = w_r ^ x;

    // Priority encoder: position of the single set bit in w_c (lowest wins).
    always_comb begin
        w_ctz = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_c[i]) begin
                w_ctz = 3'(i);
            end
        end
    end

    // Refill the ones lost from the run at the bottom of the word.
    assign nxt = ((w_rx >> 2) >> w_ctz) | w_r;

endmodule : comb_next8
`default_nettype wire

// File: rtl/comb_enum8.sv
`default_nettype none
// ============================================================================
//  Module      : comb_enum8
//  Description : Streaming enumerator. Accepts a popcount K and emits every
//                8-bit word with K ones in ascending order, flagging the last.
//  Revision    : 1.0  initial release
// ============================================================================
module comb_enum8
    import comb_enum_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4,
    parameter int IW = 7
) (
    input  logic          CLK,
    input  logic          ASYNCRESETN,
    input  logic [CW-1:0] K,
    input  logic          K_valid,
    output logic          K_ready,
    output logic [N-1:0]  O,
    output logic          O_valid,
    input  logic          O_ready,
    output logic          O_last,
    output logic [IW-1:0] IDX,
    output logic          ERR
);

    localparam logic [CW-1:0] C_K_MAX = CW'(N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_cur;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_k;
    logic          r_err;

    logic          w_k_fire;
    logic          w_k_ok;
    logic          w_o_fire;
    logic [N-1:0]  w_next;

    comb_next8 u_next (
        .x   (r_cur),
        .nxt (w_next)
    );

    // Outputs decode from registered state only; no input-to-output path.
    assign K_ready = (r_state == IDLE);
    assign O_valid = (r_state == RUN);
    assign O       = r_cur;
    assign IDX     = r_idx;
    assign ERR     = r_err;
    assign O_last  = (r_state == RUN) && (r_cur == last_word(r_k));

    assign w_k_fire = K_valid & K_ready;
    assign w_k_ok   = (K <= C_K_MAX);
    assign w_o_fire = O_valid & O_ready;

    // State register; reset abandons any enumeration in progress.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: start on a legal K, stop after the last handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_k_fire && w_k_ok) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_o_fire && O_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load first word on K acceptance, advance on each non-final
    // output handshake; an illegal K only raises a one-cycle error pulse.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_cur <= '0;
            r_idx <= '0;
            r_k   <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_k_fire & ~w_k_ok;
            if (w_k_fire && w_k_ok) begin
                r_cur <= first_word(K);
                r_idx <= '0;
                r_k   <= K;
            end else if (w_o_fire && !O_last) begin
                r_cur <= w_next;
                r_idx <= r_idx + IW'(1);
            end
        end
    end

endmodule : comb_enum8
`default_nettype wire

// File: tb/tb_comb_enum8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comb_enum8
//  Description : Directed self-checking bench for comb_enum8. Expected words
//                come from a brute-force ascending popcount search.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comb_enum8;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [3:0] K;
    logic       K_valid;
    logic       K_ready;
    logic [7:0] O;
    logic       O_valid;
    logic       O_ready;
    logic       O_last;
    logic [6:0] IDX;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    comb_enum8 dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .K           (K),
        .K_valid     (K_valid),
        .K_ready     (K_ready),
        .O           (O),
        .O_valid     (O_valid),
        .O_ready     (O_ready),
        .O_last      (O_last),
        .IDX         (IDX),
        .ERR         (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popcnt(input int w);
        int c = 0;
        for (int i = 0; i < 8; i++) c += (w >> i) & 1;
        return c;
    endfunction

    // Next word above prev (exclusive) whose popcount is k; -1 if none.
    function automatic int next_pop(input int prev, input int k);
        for (int w = prev + 1; w < 256; w++) begin
            if (popcnt(w) == k) return w;
        end
        return -1;
    endfunction

    function automatic int binom8(input int k);
        int c = 0;
        for (int w = 0; w < 256; w++) if (popcnt(w) == k) c++;
        return c;
    endfunction

    // Offer k, then walk the enumeration against the model. ready_pct sets
    // the O_ready duty; toggle_k scrambles K/K_valid during RUN; abort_idx
    // >= 0 asserts reset mid-cycle once that index is showing.
    task automatic enumerate(input int k, input int ready_pct, input bit toggle_k,
                             input int abort_idx);
        int n      = 0;
        int cycles = 0;
        int total  = binom8(k);
        int exp_w  = next_pop(-1, k);
        K       = 4'(k);
        K_valid = 1'b1;
        O_ready = 1'b0;
        @(posedge CLK); #1;
        K_valid = 1'b0;
        while (n < total && cycles < 2000) begin
            cycles++;
            check($sformatf("k%0d_valid[%0d]", k, n), O_valid, 1);
            check($sformatf("k%0d_kready[%0d]", k, n), K_ready, 0);
            check($sformatf("k%0d_word[%0d]", k, n), O, exp_w);
            check($sformatf("k%0d_idx[%0d]", k, n), IDX, n);
            check($sformatf("k%0d_last[%0d]", k, n), O_last, (n == total - 1));
            if (n == abort_idx) begin
                O_ready = 1'b0;
                #2 ASYNCRESETN = 1'b0;
                #1;
                check("rst_mid_valid", O_valid, 0);
                check("rst_mid_kready", K_ready, 1);
                check("rst_mid_last", O_last, 0);
                check("rst_mid_idx", IDX, 0);
                @(posedge CLK); #1;
                ASYNCRESETN = 1'b1;
                @(posedge CLK); #1;
                check("rst_after_valid", O_valid, 0);
                check("rst_after_kready", K_ready, 1);
                return;
            end
            O_ready = ($urandom_range(99) < ready_pct);
            if (toggle_k) begin
                K_valid = 1'($urandom_range(1));
                K       = 4'($urandom_range(15));
            end
            @(posedge CLK); #1;
            if (O_ready) begin
                n++;
                exp_w = next_pop(exp_w, k);
            end
        end
        check($sformatf("k%0d_count", k), n, total);
        O_ready = 1'b0;
        K_valid = 1'b0;
        check($sformatf("k%0d_end_valid", k), O_valid, 0);
        check($sformatf("k%0d_end_kready", k), K_ready, 1);
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        K           = 4'd0;
        K_valid     = 1'b0;
        O_ready     = 1'b0;

        // Reset values while reset is held
        #3;
        check("rst_kready", K_ready, 1);
        check("rst_valid", O_valid, 0);
        check("rst_word", O, 8'h00);
        check("rst_last", O_last, 0);
        check("rst_idx", IDX, 0);
        check("rst_err", ERR, 0);
        @(posedge CLK); @(posedge CLK); #1;
        ASYNCRESETN = 1'b1;
        @(posedge CLK); #1;

        // K=2 full speed: 28 words 0x03..0xC0
        enumerate(2, 100, 1'b0, -1);

        // K=0 then K=8 back to back: one word each, single bubble between
        enumerate(0, 100, 1'b0, -1);
        enumerate(8, 100, 1'b0, -1);

        // K=4 with random back-pressure: 70 words, held through stalls
        enumerate(4, 50, 1'b0, -1);

        // K=9: error pulse only
        K       = 4'd9;
        K_valid = 1'b1;
        @(posedge CLK); #1;
        K_valid = 1'b0;
        check("k9_err_hi", ERR, 1);
        check("k9_valid", O_valid, 0);
        check("k9_kready", K_ready, 1);
        @(posedge CLK); #1;
        check("k9_err_lo", ERR, 0);
        check("k9_valid2", O_valid, 0);
        check("k9_kready2", K_ready, 1);

        // K=3 abandoned by reset at IDX=10, then K=1 from scratch
        enumerate(3, 100, 1'b0, 10);
        enumerate(1, 100, 1'b0, -1);

        // K=5 with K/K_valid churning during RUN
        enumerate(5, 100, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_comb_enum8
`default_nettype wire

// File: doc/comb_enum8.md
# comb_enum8

Streaming enumerator that inverts the popcount direction. It accepts a target count K (0..8) over a valid/ready handshake. It then emits, one word per handshake, every 8-bit word whose population count equals K, in ascending numeric order, and flags the final word. It sits beside `PopCount8` in the bit-manipulation library and serves as a stimulus source and check partner for it.

## Interface
Parameters:
- `N`, default 8: word width. Only 8 is supported; the parameter exists for package constants.
- `CW`, default 4: count width, clog2(N+1).
- `IW`, default 7: index width, enough for max C(8,k) − 1 = 69.

Ports:
- `CLK` input 1: single clock, rising edge.
- `ASYNCRESETN` input 1: reset, asynchronous and active-low.
- `K` input CW: requested popcount.
- `K_valid` input 1: K is offered.
- `K_ready` output 1: block can accept K.
- `O` output N: current enumerated word.
- `O_valid` output 1: O is valid.
- `O_ready` input 1: consumer accepts O.
- `O_last` output 1: O is the final word for this K.
- `IDX` output IW: zero-based ordinal of O within the enumeration.
- `ERR` output 1: one-cycle pulse when K > 8 is accepted.

## Operation
- Two-state FSM: IDLE and RUN.
- IDLE:
  - `K_ready` = 1, `O_valid` = 0.
  - On `K_valid & K_ready` with K ≤ 8: load cur = (1<<K) − 1, IDX = 0, and go to RUN. K = 0 gives 0x00; K = 8 gives 0xFF.
  - On acceptance of K > 8: `ERR` = 1 for the next cycle only. State stays IDLE and no word is emitted.
- RUN:
  - `K_ready` = 0, `O_valid` = 1, `O` = cur.
  - `O_last` = (cur == ((1<<K) − 1) << (8 − K)). The stored K is used. For K = 0 and K = 8 the first word is also the last.
- Handshake `O_valid & O_ready` in RUN:
  - If `O_last`: go to IDLE.
  - Otherwise: cur ← next(cur) and IDX ← IDX + 1.
- next(x), colex successor, 8-bit arithmetic:
  - c = x & (−x)
  - r = x + c
  - next = (((r ^ x) >> 2) >> ctz(c)) | r
  - next is never evaluated on the last word, so the carry-out of r is don't-care.
- Stall: while `O_valid & !O_ready`, `O`, `O_last` and `IDX` are held stable.
- K is ignored in RUN. K is captured only at acceptance.
- Every emitted word has popcount K. Words are strictly increasing and total C(8,K).

## Timing
- Reset (asynchronous, while `ASYNCRESETN` is low):
  - state = IDLE
  - `O` = 0x00, `O_valid` = 0, `O_last` = 0, `IDX` = 0, `ERR` = 0
  - `K_ready` = 1. It is decoded from state and so is high during and after reset.
- Reset mid-RUN: `O_valid` drops immediately and asynchronously. The enumeration is abandoned with no resume, and the block is in IDLE after release.
- Latency: K accepted at edge t means first `O_valid` is asserted after edge t, so it is visible in cycle t+1.
- Throughput: one word per cycle when `O_ready` is held high.
- The last handshake returns the FSM to IDLE. The next K can be accepted one cycle later, a mandatory single bubble.
- `ERR` rises the cycle after acceptance of K > 8 and falls one cycle later.
- All outputs come from registers or from state decode. There is no combinational path from `O_ready` or `K_valid` to any output.

## Structure
- Package `comb_enum_pkg`:
  - constants `N`, `CW`, `IW`
  - FSM state enum {IDLE, RUN}
  - function `first_word(k)`
  - function `last_word(k)`
- Sub-module `comb_next8`:
  - purely combinational Gosper successor, mapping x to next(x)
  - contains the trailing-zero priority encoder on c
- Top level: FSM, cur/IDX/K registers, and handshake logic.

## Test plan
- K = 2 with `O_ready` = 1:
  - 28 words: 0x03, 0x05, 0x06, 0x09, 0x0A, 0x0C, 0x11, … ending at 0xC0.
  - `O_last` and `IDX` = 27 appear only on 0xC0, then the block returns to IDLE.
- K = 0, then K = 8:
  - Each produces exactly one word (0x00, then 0xFF) with `O_last` = 1 and `IDX` = 0.
  - There is a one-cycle bubble between them with `K_ready` = 1.
- K = 4 with random `O_ready`:
  - 70 words, all distinct, each checked as popcount 4 through `PopCount8`, strictly ascending.
  - `O`, `IDX` and `O_last` are stable across every stall.
- K = 9: `ERR` pulses for exactly 1 cycle, `O_valid` stays 0, and `K_ready` stays 1.
- K = 3 with `ASYNCRESETN` low mid-cycle after `IDX` = 10:
  - `O_valid` = 0 at once.
  - After release the block is in IDLE, and a new K = 1 yields 0x01 … 0x80.
- `K_valid` toggling in RUN with K = 5 and a changing K input: the enumeration is unaffected (56 words), and `K_ready` stays 0 until IDLE.
